// File: rtl/score_frame_buffer.sv
// Ping-pong frame buffer for classifier scores: captures one frame of signed
// class scores, tracks the running argmax and serves the last committed frame over a byte read port.
module score_frame_buffer #(
  parameter int N_CLASSES = 10,
  parameter int SCORE_W   = 32,
  parameter int ADDR_W    = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [SCORE_W-1:0]           in_score,
  input  logic                         in_last,
  output logic                         in_ready,
  input  logic                         rd_en,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic [7:0]                   rd_data,
  output logic                         rd_valid,
  output logic                         frame_done,
  output logic [$clog2(N_CLASSES)-1:0] pred_class,
  output logic [7:0]                   frame_count,
  output logic                         err_len
);

  localparam int BPS   = SCORE_W / 8;
  localparam int NB    = N_CLASSES * BPS;
  localparam int CLS_W = $clog2(N_CLASSES);
  localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(N_CLASSES - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;
  localparam logic [1:0] ST_COMMIT  = 2'd3;

  logic [1:0]                state_r;
  logic [1:0]                state_nxt_s;
  logic [CLS_W-1:0]          idx_r;
  logic [CLS_W-1:0]          idx_nxt_s;
  logic [CLS_W-1:0]          cur_idx_s;
  logic signed [SCORE_W-1:0] best_val_r;
  logic signed [SCORE_W-1:0] best_val_nxt_s;
  logic [CLS_W-1:0]          best_idx_r;
  logic [CLS_W-1:0]          best_idx_nxt_s;
  logic                      accept_s;
  logic                      greater_s;
  logic                      wr_en_s;
  logic                      err_set_s;
  logic                      commit_s;

  logic                      in_ready_r;
  logic                      rd_bank_r;
  logic                      have_frame_r;
  logic [CLS_W-1:0]          pred_class_r;
  logic [7:0]                frame_count_r;
  logic                      frame_done_r;
  logic                      err_len_r;
  logic [7:0]                rd_data_r;
  logic                      rd_valid_r;

  logic [SCORE_W-1:0]        bank0_r [N_CLASSES];
  logic [SCORE_W-1:0]        bank1_r [N_CLASSES];

  logic [ADDR_W-1:0]         cls_s;
  logic [ADDR_W-1:0]         byte_sel_s;
  logic [SCORE_W-1:0]        word_s;
  logic [7:0]                word_byte_s;
  logic [7:0]                rd_byte_s;

  assign in_ready    = in_ready_r;
  assign rd_data     = rd_data_r;
  assign rd_valid    = rd_valid_r;
  assign frame_done  = frame_done_r;
  assign pred_class  = pred_class_r;
  assign frame_count = frame_count_r;
  assign err_len     = err_len_r;

  // Frame FSM next state, beat indexing and running argmax
  always_comb begin
    accept_s       = in_valid && in_ready_r;
    cur_idx_s      = (state_r == ST_CAPTURE) ? idx_r : {CLS_W{1'b0}};
    greater_s      = $signed(in_score) > best_val_r;
    state_nxt_s    = state_r;
    idx_nxt_s      = idx_r;
    best_val_nxt_s = best_val_r;
    best_idx_nxt_s = best_idx_r;
    wr_en_s        = 1'b0;
    err_set_s      = 1'b0;
    commit_s       = 1'b0;
    case (state_r)
      ST_IDLE, ST_CAPTURE: begin
        if (accept_s) begin
          wr_en_s = 1'b1;
          // First beat seeds the argmax; later beats replace it only when strictly greater
          if ((state_r == ST_IDLE) || greater_s) begin
            best_val_nxt_s = $signed(in_score);
            best_idx_nxt_s = cur_idx_s;
          end else begin
            best_val_nxt_s = best_val_r;
            best_idx_nxt_s = best_idx_r;
          end
          if (in_last && (cur_idx_s == LAST_IDX)) begin
            state_nxt_s = ST_COMMIT;
            idx_nxt_s   = {CLS_W{1'b0}};
          end else if (in_last) begin
            err_set_s   = 1'b1;
            state_nxt_s = ST_IDLE;
            idx_nxt_s   = {CLS_W{1'b0}};
          end else if (cur_idx_s == LAST_IDX) begin
            err_set_s   = 1'b1;
            state_nxt_s = ST_DRAIN;
            idx_nxt_s   = {CLS_W{1'b0}};
          end else begin
            state_nxt_s = ST_CAPTURE;
            idx_nxt_s   = cur_idx_s + CLS_W'(1);
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_DRAIN: begin
        if (accept_s && in_last) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_COMMIT: begin
        commit_s    = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Control and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      idx_r         <= {CLS_W{1'b0}};
      best_val_r    <= {SCORE_W{1'b0}};
      best_idx_r    <= {CLS_W{1'b0}};
      in_ready_r    <= 1'b0;
      err_len_r     <= 1'b0;
      rd_bank_r     <= 1'b0;
      have_frame_r  <= 1'b0;
      pred_class_r  <= {CLS_W{1'b0}};
      frame_count_r <= 8'd0;
      frame_done_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      idx_r        <= idx_nxt_s;
      best_val_r   <= best_val_nxt_s;
      best_idx_r   <= best_idx_nxt_s;
      in_ready_r   <= (state_nxt_s != ST_COMMIT);
      frame_done_r <= commit_s;
      if (err_set_s) begin
        err_len_r <= 1'b1;
      end
      if (commit_s) begin
        rd_bank_r     <= ~rd_bank_r;
        have_frame_r  <= 1'b1;
        pred_class_r  <= best_idx_r;
        frame_count_r <= frame_count_r + 8'd1;
      end
    end
  end

  // Capture-bank write (the bank not currently selected for reads)
  always_ff @(posedge clk) begin
    for (int c = 0; c < N_CLASSES; c++) begin
      if (wr_en_s && (cur_idx_s == CLS_W'(c))) begin
        if (rd_bank_r) begin
          bank0_r[c] <= in_score;
        end else begin
          bank1_r[c] <= in_score;
        end
      end
    end
  end

  // Byte lookup in the read bank, little-endian within each score
  always_comb begin
    cls_s       = rd_addr / ADDR_W'(BPS);
    byte_sel_s  = rd_addr % ADDR_W'(BPS);
    word_s      = {SCORE_W{1'b0}};
    word_byte_s = 8'h00;
    for (int c = 0; c < N_CLASSES; c++) begin
      word_s = (cls_s == ADDR_W'(c)) ? (rd_bank_r ? bank1_r[c] : bank0_r[c]) : word_s;
    end
    for (int b = 0; b < BPS; b++) begin
      word_byte_s = (byte_sel_s == ADDR_W'(b)) ? word_s[b*8 +: 8] : word_byte_s;
    end
    if (!have_frame_r) begin
      rd_byte_s = 8'h00;
    end else if (rd_addr < ADDR_W'(NB)) begin
      rd_byte_s = word_byte_s;
    end else if (rd_addr == ADDR_W'(NB)) begin
      rd_byte_s = {{(8-CLS_W){1'b0}}, pred_class_r};
    end else begin
      rd_byte_s = 8'h00;
    end
  end

  // Registered read port, one-cycle latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r  <= 8'h00;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_en;
      if (rd_en) begin
        rd_data_r <= rd_byte_s;
      end
    end
  end

endmodule

// File: tb/tb_score_frame_buffer.sv
// Randomized scoreboard bench for score_frame_buffer: a frame-level reference
// model predicts read bytes and commit results, a monitor checks DUT outputs.
module tb_score_frame_buffer;

  localparam int N  = 10;
  localparam int SW = 32;
  localparam int AW = 6;
  localparam int NB = N * (SW / 8);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid;
  logic [SW-1:0] in_score;
  logic          in_last;
  logic          in_ready;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          frame_done;
  logic [3:0]    pred_class;
  logic [7:0]    frame_count;
  logic          err_len;

  score_frame_buffer #(.N_CLASSES(N), .SCORE_W(SW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_score(in_score),
    .in_last(in_last), .in_ready(in_ready), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .frame_done(frame_done),
    .pred_class(pred_class), .frame_count(frame_count), .err_len(err_len)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic rd_en_seen;

  logic [7:0] rd_q[$];
  int         fd_pred_q[$];
  int         fd_cnt_q[$];
  int         fd_cyc_q[$];

  // Reference model: contents of the last committed frame
  int         m_scores[N];
  logic       m_have;
  int         m_pred;
  logic [7:0] m_count;
  int         frm[16];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_en_seen <= 1'b0;
    else        rd_en_seen <= rd_en;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int a);
    int w;
    if (!m_have) return 8'h00;
    if (a < NB) begin
      w = m_scores[a / 4];
      return 8'(w >>> (8 * (a % 4)));
    end
    if (a == NB) return 8'(m_pred);
    return 8'h00;
  endfunction

  function automatic int rand_score();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 6)) - 3;
    return int'($urandom);
  endfunction

  // Output monitor: pops expected read bytes and commit results
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_valid || rd_en_seen) check("rd_valid_latency", rd_valid, rd_en_seen);
      if (rd_valid) begin
        if (rd_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rd_unexpected: rd_valid with no read outstanding, data 0x%02h", rd_data);
        end else begin
          check("rd_data", rd_data, rd_q.pop_front());
        end
      end
      if (frame_done) begin
        if (fd_pred_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL frame_done_unexpected: pulse with no commit expected, count 0x%0h", frame_count);
        end else begin
          check("pred_class", pred_class, fd_pred_q.pop_front());
          check("frame_count", frame_count, fd_cnt_q.pop_front());
          check("frame_done_cycle", cyc, fd_cyc_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input int a);
    rd_en   = 1'b1;
    rd_addr = AW'(a);
    rd_q.push_back(exp_byte(a));
    tick();
    rd_en = 1'b0;
  endtask

  task automatic send_beat(input int s, input logic last);
    int t;
    repeat ($urandom_range(0, 1)) tick();
    in_valid = 1'b1;
    in_score = s;
    in_last  = last;
    t = 0;
    while (!in_ready && t < 64) begin
      tick();
      t++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL in_ready_timeout: in_ready still 0 after %0d cycles", t);
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Sends frm[0..len-1]; commit_rd >= 0 issues a read in the commit cycle
  task automatic send_frame(input int len, input int commit_rd);
    int best;
    logic [7:0] nxt;
    for (int i = 0; i < len; i++) send_beat(frm[i], (i == len - 1));
    if (len == N) begin
      check("in_ready_commit", in_ready, 1'b0);
      best = 0;
      for (int i = 1; i < N; i++) if (frm[i] > frm[best]) best = i;
      nxt = m_count + 8'd1;
      fd_pred_q.push_back(best);
      fd_cnt_q.push_back(int'(nxt));
      fd_cyc_q.push_back(cyc + 1);
      if (commit_rd >= 0) begin
        rd_en   = 1'b1;
        rd_addr = AW'(commit_rd);
        rd_q.push_back(exp_byte(commit_rd));
      end
      tick();
      rd_en = 1'b0;
      check("in_ready_after_commit", in_ready, 1'b1);
      for (int i = 0; i < N; i++) m_scores[i] = frm[i];
      m_pred  = best;
      m_count = nxt;
      m_have  = 1'b1;
    end else begin
      tick();
      check("err_len_set", err_len, 1'b1);
      check("count_unchanged", frame_count, m_count);
    end
  endtask

  task automatic rand_frame();
    for (int i = 0; i < 16; i++) frm[i] = rand_score();
  endtask

  initial begin
    int d1[10] = '{5, -3, 100, 7, 100, 0, -50, 2, 1, 99};
    int len;
    in_valid = 1'b0; in_score = '0; in_last = 1'b0;
    rd_en = 1'b0; rd_addr = '0;
    m_have = 1'b0; m_pred = 0; m_count = 8'd0;
    for (int i = 0; i < N; i++) m_scores[i] = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_pred_class", pred_class, 4'd0);
    check("rst_frame_count", frame_count, 8'd0);
    check("rst_err_len", err_len, 1'b0);
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", in_ready, 1'b1);

    do_read(0); do_read(NB); do_read(5);

    for (int i = 0; i < N; i++) frm[i] = d1[i];
    send_frame(N, -1);
    check("directed_pred", pred_class, 4'd2);
    check("directed_count", frame_count, 8'd1);
    for (int a = 8; a < 12; a++) do_read(a);
    do_read(NB); do_read(NB + 1); do_read(63);

    rand_frame();
    frm[0] = -1;
    send_frame(N, -1);
    for (int a = 0; a < 4; a++) do_read(a);

    rand_frame();
    send_frame(5, -1);
    do_read(0); do_read(NB); do_read(13);
    rand_frame();
    send_frame(N, -1);
    do_read(NB);

    rand_frame();
    send_frame(12, -1);
    do_read(4); do_read(NB);
    rand_frame();
    send_frame(N, -1);
    do_read(4);

    rand_frame();
    send_frame(N, 8);
    do_read(8); do_read(NB);

    for (int k = 0; k < 25; k++) begin
      rand_frame();
      case ($urandom_range(0, 5))
        0: len = $urandom_range(1, N - 1);
        1: len = $urandom_range(N + 1, 16);
        default: len = N;
      endcase
      send_frame(len, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : -1);
      repeat ($urandom_range(0, 3)) do_read($urandom_range(0, 63));
    end

    while (m_count != 8'd0) begin
      rand_frame();
      send_frame(N, -1);
      if ($urandom_range(0, 15) == 0) do_read($urandom_range(0, NB));
    end
    check("wrap_count", frame_count, 8'd0);
    check("err_sticky", err_len, 1'b1);

    for (int i = 0; i < 5; i++) send_beat(rand_score(), 1'b0);
    rst_n = 1'b0;
    #2;
    check("mid_rst_in_ready", in_ready, 1'b0);
    check("mid_rst_rd_data", rd_data, 8'h00);
    check("mid_rst_rd_valid", rd_valid, 1'b0);
    check("mid_rst_frame_done", frame_done, 1'b0);
    check("mid_rst_pred_class", pred_class, 4'd0);
    check("mid_rst_frame_count", frame_count, 8'd0);
    check("mid_rst_err_len", err_len, 1'b0);
    m_have = 1'b0; m_pred = 0; m_count = 8'd0;
    tick();
    rst_n = 1'b1;
    tick();
    do_read(0); do_read(NB);
    rand_frame();
    send_frame(N, -1);
    check("post_rst_count", frame_count, 8'd1);
    do_read(0); do_read(NB);

    repeat (3) tick();
    check("rd_queue_drained", rd_q.size(), 0);
    check("commit_queue_drained", fd_pred_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_frame_buffer.md
SCORE_FRAME_BUFFER -- requirements
Module: score_frame_buffer

Interface
REQ-001 SHALL have parameter N_CLASSES, default 10, number of class scores per frame (2..64).
REQ-002 SHALL have parameter SCORE_W, default 32, signed score width, multiple of 8 (8..64).
REQ-003 SHALL have parameter ADDR_W, default 6, byte read-address width, sized to cover N_CLASSES*SCORE_W/8+1 bytes.
REQ-004 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port: rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port: in_valid  in  1  score beat valid.
REQ-007 SHALL have port: in_score  in  SCORE_W  signed score, class order 0..N_CLASSES-1.
REQ-008 SHALL have port: in_last  in  1  marks final beat of frame.
REQ-009 SHALL have port: in_ready  out  1  beat accepted when in_valid and in_ready.
REQ-010 SHALL have port: rd_en  in  1  byte read request.
REQ-011 SHALL have port: rd_addr  in  ADDR_W  byte address.
REQ-012 SHALL have port: rd_data  out  8  read byte.
REQ-013 SHALL have port: rd_valid  out  1  rd_data valid pulse.
REQ-014 SHALL have port: frame_done  out  1  one-cycle pulse on commit.
REQ-015 SHALL have port: pred_class  out  clog2(N_CLASSES)  argmax of last committed frame.
REQ-016 SHALL have port: frame_count  out  8  committed-frame counter.
REQ-017 SHALL have port: err_len  out  1  sticky frame-length error.

Function
REQ-018 SHALL store scores in two banks (ping-pong): capture bank written by input, read bank serving rd_addr.
REQ-019 SHALL implement FSM IDLE, CAPTURE, DRAIN, COMMIT; IDLE->CAPTURE on first accepted beat (beat stored as class 0).
REQ-020 SHALL hold in_ready high in IDLE, CAPTURE, DRAIN and low in COMMIT (exactly one cycle).
REQ-021 SHALL write beat k to capture bank slot k; beat index counter increments per accepted beat.
REQ-022 SHALL, on accepted beat with index N_CLASSES-1 and in_last=1, go to COMMIT.
REQ-023 SHALL, on in_last with index < N_CLASSES-1, set err_len, discard frame, return to IDLE.
REQ-024 SHALL, on accepted beat with index N_CLASSES-1 and in_last=0, set err_len, enter DRAIN, discard beats until in_last accepted, then IDLE.
REQ-025 SHALL track running argmax during capture: strictly greater signed compare, ties keep lower index.
REQ-026 SHALL in COMMIT swap banks, update pred_class, increment frame_count (wraps 255->0), pulse frame_done, set have_frame, then IDLE.
REQ-027 SHALL map read byte address a < N_CLASSES*SCORE_W/8 to class a/(SCORE_W/8), byte a mod (SCORE_W/8), little-endian.
REQ-028 SHALL return {zero-pad, pred_class} at address N_CLASSES*SCORE_W/8; 0x00 for higher addresses.
REQ-029 SHALL return 0x00 for all addresses while have_frame=0.
REQ-030 SHALL have read latency 1: rd_data/rd_valid registered on the cycle after rd_en; rd_valid=0 otherwise; rd_data holds last value.
REQ-031 SHALL serve a read issued in the COMMIT cycle from the pre-swap read bank; swap visible on the following cycle.
REQ-032 SHALL keep read bank contents unchanged by captures, errors and discarded frames.
REQ-033 SHALL clear err_len only by reset.

Reset
REQ-034 SHALL, on rst_n low, asynchronously force: FSM IDLE, in_ready 0 while asserted, rd_data 0x00, rd_valid 0, frame_done 0, pred_class 0, frame_count 0, err_len 0, have_frame 0, bank select 0, beat index 0.
REQ-035 SHALL discard any partially captured frame on reset; bank storage needs no reset.

Verification
REQ-036 SHALL verify: defaults, frame scores 0..9 = {5,-3,100,7,100,0,-50,2,1,99} -> frame_done 1 cycle after last beat, pred_class 2, frame_count 1; addr 8..11 read -> 0x64,0x00,0x00,0x00; addr 40 -> 0x02.
REQ-037 SHALL verify: score -1 at class 0 -> addr 0..3 read 0xFF x4, rd_valid exactly 1 cycle after rd_en.
REQ-038 SHALL verify: in_last on beat 4 -> err_len 1, no frame_done, frame_count and read data unchanged; next valid frame commits normally.
REQ-039 SHALL verify: 12-beat frame, in_last on beat 12 -> err_len 1, DRAIN consumes beats, no commit, next frame commits.
REQ-040 SHALL verify: read before any commit -> 0x00; read in COMMIT cycle -> old-frame byte, next cycle read -> new-frame byte; 256 frames -> frame_count 0.
REQ-041 SHALL verify: rst_n low mid-capture after 5 beats -> all outputs at reset values, subsequent read 0x00, fresh frame commits with frame_count 1.
